// File: rtl/loadable_timer_counter_if.sv
// Control and status bundle of the loadable timer/counter.
// The master drives load/configuration and the slave (the timer) returns count and status.
interface loadable_timer_counter_if #(
    parameter int WIDTH     = 8,
    parameter int PSC_WIDTH = 4
);
    logic                 load;
    logic [WIDTH-1:0]     data_in;
    logic                 enable;
    logic                 up;
    logic                 auto_reload;
    logic [PSC_WIDTH-1:0] prescale;
    logic [WIDTH-1:0]     count;
    logic                 tc;
    logic                 wrap;
    logic                 done;
    logic                 running;

    modport master (
        output load, data_in, enable, up, auto_reload, prescale,
        input  count, tc, wrap, done, running
    );

    modport slave (
        input  load, data_in, enable, up, auto_reload, prescale,
        output count, tc, wrap, done, running
    );
endinterface

// File: rtl/loadable_timer_counter.sv
// Loadable timer/counter.
// Counts up or down, runs one-shot or periodic, and has a prescaler.
// Only count, reload, prescale counter and the IDLE/RUN/DONE state (plus its
// registered status flags) are stored; tc is decoded combinationally from count.
module loadable_timer_counter #(
    parameter int WIDTH     = 8,
    parameter int PSC_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    loadable_timer_counter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     reload_q, reload_d;
    logic [PSC_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
    logic                 wrap_q, wrap_d;
    logic                 done_q, done_d;
    logic                 running_q, running_d;
    logic [WIDTH-1:0]     terminal;
    logic                 tick;

    // Terminal value follows the current direction every cycle.
    always_comb begin
        terminal = bus.up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end

    // A tick fires once psc_cnt has reached prescale; ">=" covers prescale being lowered mid-run.
    always_comb begin
        tick = (state_q == RUN) && bus.enable && (psc_cnt_q >= bus.prescale);
    end

    // Next-state logic with priority load > tick > hold (reset is applied in the register block).
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        psc_cnt_d = psc_cnt_q;
        wrap_d    = 1'b0;

        if (bus.load) begin
            // Any enable/tick in the same cycle as a load is discarded.
            count_d   = bus.data_in;
            reload_d  = bus.data_in;
            psc_cnt_d = '0;
            state_d   = RUN;
        end else if (state_q == RUN && bus.enable) begin
            if (tick) begin
                psc_cnt_d = '0;
                if (count_q != terminal) begin
                    count_d = bus.up ? count_q + {{(WIDTH-1){1'b0}}, 1'b1}
                                     : count_q - {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    wrap_d = 1'b1;
                    if (bus.auto_reload) begin
                        count_d = reload_q;
                    end else begin
                        // One-shot: count stays parked at terminal.
                        state_d = DONE;
                    end
                end
            end else begin
                psc_cnt_d = psc_cnt_q + {{(PSC_WIDTH-1){1'b0}}, 1'b1};
            end
        end

        done_d    = (state_d == DONE);
        running_d = (state_d == RUN);
    end

    // FSM and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            psc_cnt_q <= '0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            psc_cnt_q <= psc_cnt_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.tc      = (count_q == terminal);
    assign bus.wrap    = wrap_q;
    assign bus.done    = done_q;
    assign bus.running = running_q;
endmodule
